wr_merge: RTL and testbench
===========================

Name: wr_merge

Overview:
- Two-input merge stage directly downstream of the workers.
- Accepts worker-result words from two workers over independent valid/ready channels and buffers each channel in a small FIFO.
- Forwards the words one at a time to the single worker-result consumer, using round-robin arbitration and a registered output.
- Payload is opaque: no field is decoded or modified.

Parameters:
- WORKER_RESULT_WIDTH, 67, width of one worker-result word (dest option + dest addr + color + data).
- DEPTH, 2, entries per input FIFO; power of two, at least 2.
- CNT_WIDTH, 16, width of the forwarded-word counter.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- WR0_VALID  in  1  input 0 word valid.
- WR0_DATA  in  WORKER_RESULT_WIDTH  input 0 word.
- WR0_READY  out  1  input 0 can accept; registered.
- WR1_VALID  in  1  input 1 word valid.
- WR1_DATA  in  WORKER_RESULT_WIDTH  input 1 word.
- WR1_READY  out  1  input 1 can accept; registered.
- OUT_VALID  out  1  output word valid; registered.
- OUT_DATA  out  WORKER_RESULT_WIDTH  output word; registered.
- OUT_READY  in  1  consumer accepts.
- OUT_SRC  out  1  index of the input that supplied OUT_DATA.
- FWD_COUNT  out  CNT_WIDTH  number of words handed off on OUT.

Behaviour:
- Reset (asserting RST_N low, any cycle, mid-transfer included) immediately clears:
  - both FIFOs to empty;
  - OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, FWD_COUNT=0;
  - round-robin pointer to "input 0 preferred";
  - WR0_READY=0, WR1_READY=0.
- First cycle after reset release: READYs become 1.
- Transfers:
  - Input transfer on an edge where WRn_VALID && WRn_READY: word pushed to FIFO n.
  - Output transfer on an edge where OUT_VALID && OUT_READY.
- WRn_READY is registered:
  - after each edge it equals (FIFO n occupancy after that edge < DEPTH);
  - so a push on an edge that fills the FIFO drops READY for the next cycle;
  - a pop from a full FIFO raises READY the following cycle;
  - no push is accepted while full, and no word is ever overwritten.
- Output slot is free at an edge when !OUT_VALID || OUT_READY.
- At a free edge with at least one non-empty FIFO:
  - the arbiter pops one word into OUT_DATA, sets OUT_VALID=1, and sets OUT_SRC to the chosen input;
  - a push and a pop on the same FIFO at the same edge are both honoured and occupancy is unchanged.
- Arbitration:
  - only one FIFO non-empty: pick it;
  - both non-empty: pick the preferred input;
  - after any grant, the preferred input becomes the other input.
- At a free edge with both FIFOs empty: OUT_VALID goes to 0 and OUT_DATA/OUT_SRC hold.
- While OUT_VALID=1 && !OUT_READY, OUT_DATA and OUT_SRC are held stable.
- Latency: a word pushed at edge t appears on OUT after edge t+1 at the earliest (no FIFO bypass).
- Throughput: one word per cycle with OUT_READY held high.
- FWD_COUNT increments by 1 on every output transfer and wraps modulo 2^CNT_WIDTH.
- Ordering: per-input order is preserved; no ordering guarantee between inputs beyond the arbitration rule.
- FIFO pointers are log2(DEPTH) bits, wrap naturally, with a separate occupancy count of 0..DEPTH.

Test Plan:
- Reset release, no traffic → READYs=1 from the second cycle; OUT_VALID stays 0; FWD_COUNT=0.
- Single push on WR0 with data 67'h1_2345_0007_0000_002A, OUT_READY=1:
  - OUT_VALID=1 after the following edge with that data and OUT_SRC=0;
  - OUT_VALID drops the next cycle;
  - FWD_COUNT=1.
- Both inputs push every cycle (WR0 words 0,1,2,…; WR1 words 100,101,…), OUT_READY=1:
  - output alternates src 0,1,0,1 starting with src 0;
  - per-input order is intact;
  - no loss.
- OUT_READY=0 while WR1 pushes 3 words (DEPTH=2):
  - OUT holds the first word;
  - WR1_READY drops after the FIFO holds 2;
  - raising OUT_READY drains all 3 words in order.
- Assert RST_N low for one cycle while both FIFOs are full and OUT_VALID=1 → all outputs and the counter return to reset values and no stale word emerges.
- 65536 single-word transfers → FWD_COUNT wraps to 0.

Source files
------------

// File: rtl/wr_merge.sv
// Two-input merge of worker-result words: a small FIFO per input, round-robin
// arbitration between them, and a registered single-word output stage.
module wr_merge #(
  parameter int unsigned WORKER_RESULT_WIDTH = 67,
  parameter int unsigned DEPTH               = 2,
  parameter int unsigned CNT_WIDTH           = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           wr0_valid_i,
  input  logic [WORKER_RESULT_WIDTH-1:0] wr0_data_i,
  output logic                           wr0_ready_o,
  input  logic                           wr1_valid_i,
  input  logic [WORKER_RESULT_WIDTH-1:0] wr1_data_i,
  output logic                           wr1_ready_o,
  output logic                           out_valid_o,
  output logic [WORKER_RESULT_WIDTH-1:0] out_data_o,
  input  logic                           out_ready_i,
  output logic                           out_src_o,
  output logic [CNT_WIDTH-1:0]           fwd_count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

  typedef logic [WORKER_RESULT_WIDTH-1:0] word_t;

  logic [1:0]      in_valid;
  word_t           in_data [2];
  logic [1:0]      push, pop, nonempty;
  logic            slot_free, grant_any, grant;

  word_t           mem_q  [2][DEPTH];
  logic [PtrW-1:0] wptr_q [2];
  logic [PtrW-1:0] wptr_d [2];
  logic [PtrW-1:0] rptr_q [2];
  logic [PtrW-1:0] rptr_d [2];
  logic [OccW-1:0] occ_q  [2];
  logic [OccW-1:0] occ_d  [2];
  logic [1:0]      ready_q, ready_d;

  logic            out_valid_q, out_valid_d;
  word_t           out_data_q, out_data_d;
  logic            out_src_q, out_src_d;
  logic            pref_q, pref_d;
  logic [CNT_WIDTH-1:0] fwd_q, fwd_d;

  assign in_valid   = {wr1_valid_i, wr0_valid_i};
  assign in_data[0] = wr0_data_i;
  assign in_data[1] = wr1_data_i;

  // Arbitration: a lone non-empty FIFO wins, otherwise the preferred input.
  always_comb begin
    slot_free = !out_valid_q || out_ready_i;
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (occ_q[i] != '0);
    end
    grant_any = slot_free && (|nonempty);
    grant     = (&nonempty) ? pref_q : nonempty[1];
    pop[0]    = grant_any && !grant;
    pop[1]    = grant_any && grant;
    push      = in_valid & ready_q;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      wptr_d[i] = wptr_q[i] + PtrW'(push[i]);
      rptr_d[i] = rptr_q[i] + PtrW'(pop[i]);
      occ_d[i]  = occ_q[i];
      unique case ({push[i], pop[i]})
        2'b10:   occ_d[i] = occ_q[i] + OccW'(1);
        2'b01:   occ_d[i] = occ_q[i] - OccW'(1);
        default: occ_d[i] = occ_q[i];
      endcase
      ready_d[i] = (occ_d[i] < DepthOcc);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    pref_d      = pref_q;
    fwd_d       = fwd_q + CNT_WIDTH'(out_valid_q && out_ready_i);
    if (slot_free) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = mem_q[grant][rptr_q[grant]];
        out_src_d  = grant;
        pref_d     = ~grant;
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        occ_q[i]  <= '0;
      end
      ready_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      pref_q      <= 1'b0;
      fwd_q       <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        occ_q[i]  <= occ_d[i];
      end
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      pref_q      <= pref_d;
      fwd_q       <= fwd_d;
    end
  end

  assign wr0_ready_o = ready_q[0];
  assign wr1_ready_o = ready_q[1];
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign fwd_count_o = fwd_q;

endmodule

// File: tb/tb_wr_merge.sv
// Directed self-checking bench for wr_merge: reset, single word, interleave,
// backpressure, mid-flight reset and counter wrap.
module tb_wr_merge;

  localparam int unsigned W = 67;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         wr0_valid, wr1_valid, out_ready;
  logic [W-1:0] wr0_data, wr1_data;
  logic         wr0_ready, wr1_ready, out_valid, out_src;
  logic [W-1:0] out_data;
  logic [15:0]  fwd_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wr_merge #(
    .WORKER_RESULT_WIDTH(W),
    .DEPTH(2),
    .CNT_WIDTH(16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .wr0_valid_i (wr0_valid),
    .wr0_data_i  (wr0_data),
    .wr0_ready_o (wr0_ready),
    .wr1_valid_i (wr1_valid),
    .wr1_data_i  (wr1_data),
    .wr1_ready_o (wr1_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .out_src_o   (out_src),
    .fwd_count_o (fwd_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
    rst_ni    = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0; out_ready = 1'b0;
    wr0_data = '0; wr1_data = '0;
    step(); step();
    n_tests++; if (wr0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0: got %b want 0", wr0_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_tests++; if (fwd_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fwd_count); end
    rst_ni = 1'b1;
    #1;
    n_tests++; if (wr1_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready1_early: got %b want 0", wr1_ready); end
    step();
    n_tests++; if (wr0_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready0: got %b want 1", wr0_ready); end
    n_tests++; if (wr1_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready1: got %b want 1", wr1_ready); end
    repeat (3) step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    n_tests++; if (fwd_count !== 16'd0) begin n_fail++; $display("FAIL idle_count: got %0d want 0", fwd_count); end
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    w = 67'h1_2345_0007_0000_002A;
    out_ready = 1'b1; wr0_valid = 1'b1; wr0_data = w;
    step();
    wr0_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_nobypass: got %b want 0", out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_tests++; if (out_data !== w) begin n_fail++; $display("FAIL single_data: got %h want %h", out_data, w); end
    n_tests++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL single_src: got %b want 0", out_src); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %b want 0", out_valid); end
    n_tests++; if (fwd_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", fwd_count); end
    n_tests++; if (out_data !== w) begin n_fail++; $display("FAIL single_hold: got %h want %h", out_data, w); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] exp_w;
    logic         acc0, acc1;
    int           nout;
    out_ready = 1'b1;
    do_reset();
    nout = 0;
    wr0_valid = 1'b1; wr0_data = W'(0);
    wr1_valid = 1'b1; wr1_data = W'(100);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (nout >= 12 && q0.size() == 0 && q1.size() == 0) break;
      acc0 = wr0_valid && wr0_ready;
      acc1 = wr1_valid && wr1_ready;
      if (acc0) q0.push_back(wr0_data);
      if (acc1) q1.push_back(wr1_data);
      if (out_valid) begin
        if (nout < 12) begin
          n_tests++;
          if (out_src !== nout[0]) begin
            n_fail++; $display("FAIL b2b_src[%0d]: got %b want %b", nout, out_src, nout[0]);
          end
        end
        n_tests++;
        if (out_src ? (q1.size() == 0) : (q0.size() == 0)) begin
          n_fail++; $display("FAIL b2b_extra[%0d]: got %h want none", nout, out_data);
        end else begin
          exp_w = out_src ? q1.pop_front() : q0.pop_front();
          if (out_data !== exp_w) begin
            n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", nout, out_data, exp_w);
          end
        end
        nout++;
      end
      step();
      if (acc0) wr0_data = wr0_data + W'(1);
      if (acc1) wr1_data = wr1_data + W'(1);
      if (nout >= 12) begin
        wr0_valid = 1'b0; wr1_valid = 1'b0;
      end
    end
    n_tests++; if (q0.size() + q1.size() != 0) begin n_fail++; $display("FAIL b2b_loss: got %0d pending want 0", q0.size() + q1.size()); end
    n_tests++; if (fwd_count !== 16'(nout)) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", fwd_count, nout); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] wa, wb, wc;
    logic [W-1:0] exp_q[$];
    int           k;
    wa = 67'h7_0000_0000_0000_0A01;
    wb = 67'h7_0000_0000_0000_0A02;
    wc = 67'h7_0000_0000_0000_0A03;
    out_ready = 1'b0; wr1_valid = 1'b1; wr1_data = wa;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid0: got %b want 0", out_valid); end
    wr1_data = wb;
    step();
    n_tests++; if (out_data !== wa || out_valid !== 1'b1 || out_src !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: got v=%b s=%b %h want v=1 s=1 %h", out_valid, out_src, out_data, wa);
    end
    n_tests++; if (wr1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b want 1", wr1_ready); end
    wr1_data = wc;
    step();
    wr1_valid = 1'b0;
    n_tests++; if (wr1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", wr1_ready); end
    repeat (3) begin
      step();
      n_tests++; if (out_data !== wa || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", out_valid, out_data, wa);
      end
      n_tests++; if (wr1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold: got %b want 0", wr1_ready); end
    end
    exp_q = '{wa, wb, wc};
    k = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && k < 3; cyc++) begin
      if (out_valid) begin
        n_tests++; if (out_data !== exp_q[k]) begin n_fail++; $display("FAIL bp_drain[%0d]: got %h want %h", k, out_data, exp_q[k]); end
        k++;
      end
      step();
    end
    n_tests++; if (k != 3) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 3", k); end
    n_tests++; if (wr1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", wr1_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    wr0_valid = 1'b1; wr0_data = 67'h5_0000_0000_0000_0000;
    wr1_valid = 1'b1; wr1_data = 67'h6_0000_0000_0000_0000;
    for (int cyc = 0; cyc < 6; cyc++) begin
      logic a0, a1;
      a0 = wr0_ready; a1 = wr1_ready;
      step();
      if (a0) wr0_data = wr0_data + W'(1);
      if (a1) wr1_data = wr1_data + W'(1);
    end
    n_tests++; if (wr0_ready !== 1'b0 || wr1_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got r0=%b r1=%b v=%b want 0 0 1", wr0_ready, wr1_ready, out_valid);
    end
    rst_ni = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_src !== 1'b0) begin n_fail++; $display("FAIL mid_out: got v=%b s=%b want 0 0", out_valid, out_src); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL mid_data: got %h want 0", out_data); end
    n_tests++; if (fwd_count !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", fwd_count); end
    n_tests++; if (wr0_ready !== 1'b0 || wr1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b %b want 0 0", wr0_ready, wr1_ready); end
    step();
    rst_ni = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got v=%b %h want v=0", out_valid, out_data); end
    end
    n_tests++; if (wr0_ready !== 1'b1 || wr1_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_back: got %b %b want 1 1", wr0_ready, wr1_ready); end
  endtask

  task automatic test_wrap();
    int  pushes, hand;
    bit  seen_ff;
    logic acc;
    out_ready = 1'b1;
    do_reset();
    pushes = 0; hand = 0; seen_ff = 1'b0;
    wr0_valid = 1'b1; wr0_data = '0;
    for (int cyc = 0; cyc < 70000; cyc++) begin
      acc = wr0_valid && wr0_ready;
      if (acc) pushes++;
      if (out_valid) hand++;
      step();
      if (acc) wr0_data = wr0_data + W'(1);
      if (pushes == 65536) wr0_valid = 1'b0;
      if (hand == 65535 && !seen_ff) begin
        seen_ff = 1'b1;
        n_tests++; if (fwd_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %h want ffff", fwd_count); end
      end
      if (hand == 65536) break;
    end
    n_tests++; if (hand != 65536) begin n_fail++; $display("FAIL wrap_transfers: got %0d want 65536", hand); end
    n_tests++; if (fwd_count !== 16'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", fwd_count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got %b want 0", out_valid); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
